bgr_startup_ctrl: RTL and testbench
===================================

# bgr_startup_ctrl

Digital start-up sequencer for the bandgap reference macro `bgr_top`. It drives the macro's `porst` kick input and watches a digitized "VBG in range" comparator flag coming back from the analog side. The block pulses `porst`, waits for the core to settle, and qualifies the reference before declaring it ready. It retries on failure and re-kicks on brown-out, and sits in the always-on digital domain next to the analog macro.

## Interface
Parameters:
- `PULSE_CYCLES`, 16: width of each `porst` pulse, in clk cycles (≥1).
- `SETTLE_CYCLES`, 1024: wait after the pulse before qualification (≥1).
- `GOOD_CYCLES`, 8: consecutive synchronized good samples needed to qualify; also the consecutive bad samples that trigger brown-out (≥1).
- `CHECK_WINDOW`, 64: maximum cycles spent in CHECK (≥ `GOOD_CYCLES`).
- `MAX_RETRIES`, 3: re-kicks allowed after the first attempt before FAIL.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: sequencer enable, level-sensitive.
- `vbg_good` in 1: comparator flag, asynchronous to `clk`.
- `porst` out 1: registered kick to `bgr_top.porst`, active-high.
- `bgr_ready` out 1: registered; reference qualified.
- `bgr_fail` out 1: registered; sticky failure.
- `retry_cnt` out `$clog2(MAX_RETRIES+1)`: re-kicks consumed in the current attempt sequence.

## Operation
- `vbg_good` passes through a 2-flop synchronizer. All decisions use the synchronized value `good_s`.
- States:
  - IDLE: all outputs low; `retry_cnt` = 0.
  - KICK: `porst` = 1.
  - SETTLE
  - CHECK
  - READY: `bgr_ready` = 1.
  - FAIL: `bgr_fail` = 1.
- Transitions (evaluated every rising `clk`):
  - IDLE → KICK when `en` = 1.
  - KICK → SETTLE after `PULSE_CYCLES` cycles in KICK.
  - SETTLE → CHECK after `SETTLE_CYCLES` cycles.
  - CHECK → READY when the `good_s` streak reaches `GOOD_CYCLES`. The streak counter clears on any `good_s` = 0.
  - CHECK, window expires without qualifying, `retry_cnt` < `MAX_RETRIES` → KICK, and `retry_cnt` increments.
  - CHECK, window expires without qualifying, `retry_cnt` = `MAX_RETRIES` → FAIL.
  - READY → KICK when `good_s` = 0 for `GOOD_CYCLES` consecutive cycles (brown-out). `retry_cnt` clears to 0 on this transition.
  - FAIL is sticky until `en` = 0 or `rst`.
  - `en` = 0 in any state → IDLE on the next edge. This has priority over every other transition and clears all counters.
- Simultaneous events in the same cycle:
  - Window expiry and streak reaching `GOOD_CYCLES` → READY wins.
  - `en` = 0 → IDLE wins over everything.
- One shared cycle counter, width `$clog2(max(PULSE_CYCLES, SETTLE_CYCLES, CHECK_WINDOW)+1)`. It is reloaded on every state entry and saturates without wrapping. A separate streak counter of width `$clog2(GOOD_CYCLES+1)` saturates at `GOOD_CYCLES`.

## Timing
- Reset values: state IDLE; `porst`, `bgr_ready`, `bgr_fail` = 0; `retry_cnt` = 0; synchronizer flops = 0.
- `rst` asserted mid-operation, including during a `porst` pulse, forces all reset values on the next edge. `porst` may therefore be truncated.
- `en` sampled high at edge N → `porst` = 1 from edge N+1 for exactly `PULSE_CYCLES` cycles, i.e. it falls at edge N+1+`PULSE_CYCLES`.
- CHECK is entered `SETTLE_CYCLES` cycles after `porst` falls.
- `vbg_good` → `good_s` latency is 2 cycles. A good level stable from before CHECK entry gives `bgr_ready` = 1 exactly `GOOD_CYCLES` cycles after CHECK entry.
- Brown-out: `porst` rises `GOOD_CYCLES` cycles after `good_s` first falls, which is `GOOD_CYCLES`+2 cycles after the raw input falls. `bgr_ready` drops on the same edge.
- All outputs are flop outputs with no combinational path from inputs. `bgr_ready` and `bgr_fail` are never high together.

## Structure
- Package `bgr_ctrl_pkg` holds:
  - the state enum (IDLE, KICK, SETTLE, CHECK, READY, FAIL);
  - a `max3` constant function used for counter sizing.
- Sub-module `sync_2ff`: a 1-bit, 2-flop synchronizer with synchronous active-high reset to 0. It is reused by other analog-status inputs.
- Top: one FSM, the shared cycle counter, the streak counter and the retry counter. All outputs are registered.

## Test plan
Bench parameters: `PULSE_CYCLES`=4, `SETTLE_CYCLES`=16, `GOOD_CYCLES`=4, `CHECK_WINDOW`=12, `MAX_RETRIES`=2.

- Nominal: `vbg_good` = 1 throughout, `en` rises at edge 10.
  - `porst` high on edges 11–14.
  - CHECK entered at edge 31.
  - `bgr_ready` = 1 at edge 35, `retry_cnt` = 0.
- Always bad: `vbg_good` = 0.
  - Three `porst` pulses; `retry_cnt` goes 0 → 1 → 2.
  - `bgr_fail` = 1 after the third window; `porst` never rises again.
  - Dropping `en` → IDLE with `bgr_fail` = 0.
- Glitchy qualify: `good_s` pattern 1,1,1,0,1,1,1,1 in CHECK.
  - Streak resets on the 0; `bgr_ready` asserts after the 4th consecutive 1.
  - Window-edge tie resolves to READY.
- Brown-out: from READY, hold `vbg_good` = 0 for 3 cycles then return to 1 → no kick. Hold it low for ≥6 cycles → `porst` rises `GOOD_CYCLES`+2 cycles after the fall, `bgr_ready` drops on the same edge, and `retry_cnt` = 0.
- Abort mid-pulse:
  - `en` drops 2 cycles into KICK → `porst` = 0 next edge, state IDLE.
  - `rst` pulse during SETTLE → all outputs at reset values next edge, then a fresh full sequence.

Source files
------------

// File: rtl/bgr_ctrl_pkg.sv
// bgr_ctrl_pkg: sequencer state encoding and counter-sizing helper shared by the bandgap start-up logic
package bgr_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, KICK, SETTLE, CHECK, READY, FAIL} state_t;
  function automatic int max3(input int a, input int b, input int c);
    return a > b ? (a > c ? a : c) : (b > c ? b : c);
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: 1-bit two-flop synchronizer, sync active-high reset to 0; in clk, rst, d; out q
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk) begin
    if (rst) {q, meta} <= 2'b00;
    else {q, meta} <= {meta, d};
  end
endmodule

// File: rtl/bgr_startup_ctrl.sv
// bgr_startup_ctrl: bandgap kick/settle/qualify sequencer; in clk, rst, en, vbg_good; out porst, bgr_ready, bgr_fail, retry_cnt
module bgr_startup_ctrl #(
  parameter int PULSE_CYCLES  = 16,
  parameter int SETTLE_CYCLES = 1024,
  parameter int GOOD_CYCLES   = 8,
  parameter int CHECK_WINDOW  = 64,
  parameter int MAX_RETRIES   = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic                             vbg_good,
  output logic                             porst,
  output logic                             bgr_ready,
  output logic                             bgr_fail,
  output logic [$clog2(MAX_RETRIES+1)-1:0] retry_cnt
);
  import bgr_ctrl_pkg::*;
  localparam int CW = $clog2(max3(PULSE_CYCLES, SETTLE_CYCLES, CHECK_WINDOW) + 1);
  localparam int SW = $clog2(GOOD_CYCLES + 1);
  localparam int RW = $clog2(MAX_RETRIES + 1);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [SW-1:0] streak, streak_n;
  logic [RW-1:0] retry_n;
  logic good_s, pulse_done, settle_done, window_done, streak_hit;
  logic porst_n, ready_n, fail_n;
  sync_2ff u_sync (
    .clk(clk),
    .rst(rst),
    .d  (vbg_good),
    .q  (good_s)
  );
  assign pulse_done  = cnt == CW'(PULSE_CYCLES - 1);
  assign settle_done = cnt == CW'(SETTLE_CYCLES - 1);
  assign window_done = cnt == CW'(CHECK_WINDOW - 1);
  // streak counts good samples in CHECK and bad samples in READY; the next matching sample completes it
  assign streak_hit  = streak == SW'(GOOD_CYCLES - 1);
  always_comb begin
    state_n = state;
    if (!en) state_n = IDLE;
    else
      case (state)
        IDLE:    state_n = KICK;
        KICK:    state_n = pulse_done ? SETTLE : KICK;
        SETTLE:  state_n = settle_done ? CHECK : SETTLE;
        CHECK:   state_n = good_s && streak_hit ? READY :
                           !window_done ? CHECK :
                           retry_cnt == RW'(MAX_RETRIES) ? FAIL : KICK;
        READY:   state_n = !good_s && streak_hit ? KICK : READY;
        FAIL:    state_n = FAIL;
        default: state_n = IDLE;
      endcase
  end
  assign streak_n = (state == CHECK && good_s) || (state == READY && !good_s) ?
                    (streak == SW'(GOOD_CYCLES) ? streak : streak + SW'(1)) : '0;
  assign retry_n  = !en ? '0 :
                    state == READY && state_n == KICK ? '0 :
                    state == CHECK && state_n == KICK ? retry_cnt + RW'(1) : retry_cnt;
  // outputs decode the next state so they change on the same edge as the state
  always_comb begin
    porst_n = state_n == KICK;
    ready_n = state_n == READY;
    fail_n  = state_n == FAIL;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      streak    <= '0;
      retry_cnt <= '0;
      porst     <= 1'b0;
      bgr_ready <= 1'b0;
      bgr_fail  <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= !en || state_n != state ? '0 : cnt == '1 ? cnt : cnt + CW'(1);
      streak    <= !en || state_n != state ? '0 : streak_n;
      retry_cnt <= retry_n;
      porst     <= porst_n;
      bgr_ready <= ready_n;
      bgr_fail  <= fail_n;
    end
  end
endmodule

// File: tb/tb_bgr_startup_ctrl.sv
// tb_bgr_startup_ctrl: scoreboard bench for the bandgap start-up sequencer
module tb_bgr_startup_ctrl;
  localparam int P = 4;
  localparam int S = 16;
  localparam int G = 4;
  localparam int W = 12;
  localparam int M = 2;
  localparam logic [4:0] K0 = 5'b00000;
  localparam logic [4:0] KP = 5'b10000;
  localparam logic [4:0] KR = 5'b01000;
  typedef struct {
    int         cyc;
    string      tag;
    logic [4:0] v;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic vbg_good = 1'b1;
  logic porst, bgr_ready, bgr_fail;
  logic [1:0] retry_cnt;
  logic [4:0] obs;
  int ec = 0;
  int n_vec = 0;
  int n_err = 0;
  int n, c, c2, ks, cc, r, m;
  exp_t sb[$];
  exp_t e;
  bgr_startup_ctrl #(
    .PULSE_CYCLES (P),
    .SETTLE_CYCLES(S),
    .GOOD_CYCLES  (G),
    .CHECK_WINDOW (W),
    .MAX_RETRIES  (M)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .vbg_good (vbg_good),
    .porst    (porst),
    .bgr_ready(bgr_ready),
    .bgr_fail (bgr_fail),
    .retry_cnt(retry_cnt)
  );
  assign obs = {porst, bgr_ready, bgr_fail, retry_cnt};
  always #5 clk = ~clk;
  always @(posedge clk) ec <= ec + 1;
  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s @edge %0d: observed %0h, required %0h", tag, ec, got, exp);
    end
  endtask
  task automatic expect_at(input int cyc, input string tag, input logic [4:0] v);
    exp_t x;
    x.cyc = cyc;
    x.tag = tag;
    x.v = v;
    sb.push_back(x);
  endtask
  task automatic upto(input int k);
    while (ec < k) begin
      @(posedge clk);
      #1;
    end
  endtask
  always @(negedge clk) begin
    chk("excl", int'(bgr_ready & bgr_fail), 0);
    while (sb.size() > 0 && sb[0].cyc <= ec) begin
      e = sb.pop_front();
      chk(e.tag, int'(obs), int'(e.v));
      if (e.cyc != ec) chk("late", ec, e.cyc);
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: edge %0d, required completion", ec);
    $fatal(1);
  end
  initial begin
    for (int k = 1; k <= 3; k++) expect_at(k, "rst", K0);
    upto(3);
    rst = 1'b0;
    upto(10);
    en = 1'b1;
    expect_at(10, "nom_idle", K0);
    for (int k = 11; k <= 14; k++) expect_at(k, "nom_porst", KP);
    expect_at(15, "nom_pfall", K0);
    expect_at(34, "nom_check", K0);
    expect_at(35, "nom_ready", KR);
    upto(36);
    en = 1'b0;
    vbg_good = 1'b0;
    expect_at(ec + 1, "bad_idle", K0);
    upto(ec + 3);
    en = 1'b1;
    n = ec;
    ks = n + 1;
    for (int a = 0; a <= M; a++) begin
      expect_at(ks, "bad_kick", {3'b100, 2'(a)});
      expect_at(ks + P - 1, "bad_pend", {3'b100, 2'(a)});
      expect_at(ks + P, "bad_settle", {3'b000, 2'(a)});
      cc = ks + P + S;
      expect_at(cc + W - 1, "bad_win", {3'b000, 2'(a)});
      ks = cc + W;
    end
    expect_at(ks, "bad_fail", 5'b00110);
    for (int j = 1; j <= 8; j++) expect_at(ks + j, "bad_sticky", 5'b00110);
    upto(ks + 8);
    en = 1'b0;
    expect_at(ec + 1, "bad_clr", K0);
    vbg_good = 1'b1;
    upto(ec + 3);
    en = 1'b1;
    n = ec;
    c = n + 1 + P + S;
    expect_at(c + 3, "gl_mid", K0);
    expect_at(c + 7, "gl_pre", K0);
    expect_at(c + 8, "gl_ready", KR);
    upto(c + 1);
    vbg_good = 1'b0;
    upto(c + 2);
    vbg_good = 1'b1;
    upto(c + 9);
    en = 1'b0;
    vbg_good = 1'b0;
    expect_at(ec + 1, "tie_idle", K0);
    upto(ec + 3);
    en = 1'b1;
    n = ec;
    c = n + 1 + P + S;
    expect_at(c + 11, "tie_pre", K0);
    expect_at(c + 12, "tie_ready", KR);
    upto(c + 6);
    vbg_good = 1'b1;
    upto(c + 13);
    en = 1'b0;
    vbg_good = 1'b0;
    expect_at(ec + 1, "bo_idle", K0);
    upto(ec + 3);
    en = 1'b1;
    n = ec;
    c = n + 1 + P + S;
    c2 = c + W + P + S;
    expect_at(c + W, "bo_retry", 5'b10001);
    expect_at(c2 + G, "bo_ready", 5'b01001);
    upto(c + W);
    vbg_good = 1'b1;
    upto(c2 + G + 2);
    r = ec;
    for (int j = 1; j <= 8; j++) expect_at(r + j, "bo_glitch", 5'b01001);
    vbg_good = 1'b0;
    upto(r + 3);
    vbg_good = 1'b1;
    upto(r + 10);
    r = ec;
    expect_at(r + G + 1, "bo_pre", 5'b01001);
    expect_at(r + G + 2, "bo_kick", KP);
    vbg_good = 1'b0;
    upto(r + G + 4);
    vbg_good = 1'b1;
    en = 1'b0;
    expect_at(ec + 1, "bo_idle2", K0);
    upto(ec + 3);
    en = 1'b1;
    n = ec;
    expect_at(n + 2, "ab_kick", KP);
    expect_at(n + 3, "ab_idle", K0);
    expect_at(n + 5, "ab_stay", K0);
    upto(n + 2);
    en = 1'b0;
    upto(n + 6);
    en = 1'b1;
    n = ec;
    expect_at(n + 1, "rk_kick", KP);
    expect_at(n + 2, "rk_rst", K0);
    upto(n + 1);
    rst = 1'b1;
    upto(n + 2);
    rst = 1'b0;
    en = 1'b0;
    upto(n + 5);
    en = 1'b1;
    n = ec;
    m = n + P + 3;
    expect_at(n + P, "rs_kick", KP);
    expect_at(n + P + 2, "rs_settle", K0);
    expect_at(m, "rs_rst", K0);
    expect_at(m + 1, "rs_kick2", KP);
    expect_at(m + P, "rs_pend2", KP);
    expect_at(m + P + 1, "rs_settle2", K0);
    expect_at(m + P + S + G, "rs_pre", K0);
    expect_at(m + 1 + P + S + G, "rs_ready", KR);
    upto(m - 1);
    rst = 1'b1;
    upto(m);
    rst = 1'b0;
    upto(m + P + S + G + 3);
    chk("drain", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
